// File: rtl/cla_seq_add.sv
// rtl/cla_seq_add.sv - nibble-serial add/subtract through one shared 4-bit CLA slice
// Operands are latched at accept; one nibble per RUN cycle, LSB nibble first.

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       g_g,
  output logic       p_g
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = c0;
  assign c[1] = g[0] | (p[0] & c0);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);

  assign s   = p ^ c;
  assign g_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p_g = &p;
endmodule

module cla_seq_add #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf_q;
  logic [IW-1:0]    idx;

  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  logic [3:0]       sl_s;
  logic             sl_g;
  logic             sl_p;
  logic             sl_c;

  assign sl_a = op_a[{idx, 2'b00} +: 4];
  assign sl_b = op_b[{idx, 2'b00} +: 4];

  cla4 u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .c0  (carry),
    .s   (sl_s),
    .g_g (sl_g),
    .p_g (sl_p)
  );

  assign sl_c = sl_g | (sl_p & carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      carry  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (flush) begin
      state  <= IDLE;
      idx    <= '0;
      result <= '0;
      carry  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + 1, so the inversion happens once at accept.
            op_a   <= a;
            op_b   <= sub ? ~b : b;
            carry  <= sub | cin;
            idx    <= '0;
            result <= '0;
            ovf_q  <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          result[{idx, 2'b00} +: 4] <= sl_s;
          carry <= sl_c;
          if (idx == LAST) begin
            ovf_q <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sl_s[3] != op_a[WIDTH-1]);
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign sum       = result;
  assign cout      = carry;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_seq_add.sv
// tb/tb_cla_seq_add.sv - randomized and directed checks of cla_seq_add against an arithmetic model
`timescale 1ns/1ps
module tb_cla_seq_add;
  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_ready;
  logic             out_valid;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic [WIDTH-1:0] sum;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_seq_add #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result from integer arithmetic: {cout, ovf, sum}.
  function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic ci, input logic s);
    longint ux, uy, sx, sy, r, ur, smax, smin, lim;
    logic c, v;
    ux   = longint'(x);
    uy   = longint'(y);
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    lim  = longint'(1) << WIDTH;
    smax = (longint'(1) << (WIDTH - 1)) - 1;
    smin = -(longint'(1) << (WIDTH - 1));
    if (s) begin
      r  = sx - sy;
      ur = ux - uy;
      c  = (ux >= uy);
    end else begin
      r  = sx + sy + longint'(ci);
      ur = ux + uy + longint'(ci);
      c  = (ur >= lim);
    end
    v = (r > smax) || (r < smin);
    return {c, v, ur[WIDTH-1:0]};
  endfunction

  logic             m_busy = 1'b0;
  logic             m_valid = 1'b0;
  int               m_wait = 0;
  logic [WIDTH-1:0] m_sum = '0;
  logic             m_cout = 1'b0;
  logic             m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_wait  <= 0;
    end else if (flush) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        {m_cout, m_ovf, m_sum} <= ref_op(a, b, cin, sub);
        m_busy <= 1'b1;
        m_wait <= NSLICE;
      end
    end else if (m_valid) begin
      if (out_ready) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b0;
      end
    end else begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) m_valid <= 1'b1;
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, !m_busy);
    check("busy", busy, m_busy);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("sum", sum, m_sum);
      check("cout", cout, m_cout);
      check("ovf", ovf, m_ovf);
    end
  end

  task automatic accept_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                           input logic xc, input logic xs, output int acc);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1'b1);
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    @(posedge clk);
    acc = cyc;
    @(negedge clk);
    in_valid = 1'(($urandom_range(0, 1)));
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc,
                        input logic xs, input int hold, input bit lit, input logic [WIDTH-1:0] e_sum,
                        input logic e_c, input logic e_v, output int acc);
    int n;
    accept_op(xa, xb, xc, xs, acc);
    wait_valid(n);
    check("latency", n, NSLICE);
    if (lit) begin
      check("lit_sum", sum, e_sum);
      check("lit_cout", cout, e_c);
      check("lit_ovf", ovf, e_v);
      check("model_sum", m_sum, e_sum);
      check("model_cout", m_cout, e_c);
      check("model_ovf", m_ovf, e_v);
    end
    repeat (hold) @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_handshake", in_ready, 1'b1);
  endtask

  initial begin
    int acc1, acc2, acc3, n;
    #2 rst_n = 1'b0;
    #1;
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b1, 16'h5555, 1'b0, 1'b0, acc1);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 16'h0000, 1'b1, 1'b0, acc1);
    run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 16'h8000, 1'b0, 1'b1, acc1);

    // Backpressure for 3 cycles, then back-to-back ops at the minimum period.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 3, 1'b1, 16'h5555, 1'b0, 1'b0, acc1);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b1, 16'h7FFF, 1'b1, 1'b1, acc2);
    run_op(16'h0003, 16'h0005, 1'b0, 1'b1, 0, 1'b1, 16'hFFFE, 1'b0, 1'b0, acc3);
    check("bp_period", acc2 - acc1, NSLICE + 5);
    check("min_period", acc3 - acc2, NSLICE + 2);

    accept_op(16'h1111, 16'h2222, 1'b0, 1'b0, acc1);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_sum", sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 16'h0100, 1'b0, 1'b0, acc1);

    accept_op(16'hABCD, 16'h1111, 1'b0, 1'b0, acc1);
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_run_in_ready", in_ready, 1);
    check("flush_run_out_valid", out_valid, 0);
    repeat (NSLICE + 2) @(negedge clk);
    check("flush_run_no_result", out_valid, 0);

    accept_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, acc1);
    in_valid = 1'b0;
    wait_valid(n);
    check("flush_done_reached", out_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_done_in_ready", in_ready, 1);
    check("flush_done_out_valid", out_valid, 0);

    flush = 1'b1;
    in_valid = 1'b1;
    a = 16'h0101;
    b = 16'h0202;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_idle_no_accept", busy, 0);
    check("flush_idle_in_ready", in_ready, 1);

    for (int i = 0; i < 150; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'b0, '0, 1'b0, 1'b0, acc1);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
